// File: rtl/inst_fetch_queue_pkg.sv
// Shared fetch-side types: instruction word, word address and the
// {inst, pc} entry held in the prefetch queue and used by decode tracing.
package inst_fetch_queue_pkg;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;

    typedef logic [ADDR_W-1:0] address_t;
    typedef logic [INST_W-1:0] inst_t;

    typedef struct packed {
        inst_t    inst;
        address_t pc;
    } fetch_entry_t;

    function automatic address_t addr_inc(input address_t a);
        return a + address_t'(1);
    endfunction

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries with flush.
// Ports: clk, reset, flush, push/push_entry, pop, head (oldest entry), count.
module fetch_fifo
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_entry,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;

    // Storage needs no reset; head is only meaningful while count != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: owns fetch_pc, issues word fetches, buffers
// responses in a prefetch queue and presents inst/pc/npc with valid/ready.
// Ports: clk, reset, imem_en/imem_addr/imem_data, redirect/redirect_pc,
// decode_ready, valid, inst, pc, npc.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int       QUEUE_DEPTH = 2,
    parameter address_t RESET_PC    = '0
) (
    input  logic     clk,
    input  logic     reset,
    output logic     imem_en,
    output address_t imem_addr,
    input  inst_t    imem_data,
    input  logic     redirect,
    input  address_t redirect_pc,
    input  logic     decode_ready,
    output logic     valid,
    output inst_t    inst,
    output address_t pc,
    output address_t npc
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    address_t     fetch_pc;
    address_t     issued_pc;
    logic         inflight;
    logic         kill;
    logic         pop;
    logic         push;
    logic [CW-1:0] count;
    logic [CW:0]  pending;
    fetch_entry_t head;
    fetch_entry_t resp;

    assign valid = (count != '0);
    assign pop   = valid & decode_ready & ~redirect;
    assign push  = inflight & ~kill;

    // Slots that will be taken after this edge; a fetch issues only if
    // its response is guaranteed a free queue entry.
    assign pending = {1'b0, count}
                   + {{CW{1'b0}}, inflight}
                   - {{CW{1'b0}}, pop};

    assign imem_en   = ~reset & ~redirect
                     & (pending < (CW+1)'(QUEUE_DEPTH));
    assign imem_addr = fetch_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            issued_pc <= '0;
            inflight  <= 1'b0;
            kill      <= 1'b0;
        end else begin
            inflight <= imem_en;
            kill     <= redirect & inflight;
            if (imem_en) begin
                issued_pc <= fetch_pc;
            end
            if (redirect) begin
                fetch_pc <= redirect_pc;
            end else if (imem_en) begin
                fetch_pc <= addr_inc(fetch_pc);
            end
        end
    end

    assign resp.inst = imem_data;
    assign resp.pc   = issued_pc;

    fetch_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect),
        .push       (push),
        .push_entry (resp),
        .pop        (pop),
        .head       (head),
        .count      (count)
    );

    // Outputs read as zero whenever the queue is empty.
    assign inst = valid ? head.inst : '0;
    assign pc   = valid ? head.pc : '0;
    assign npc  = valid ? addr_inc(head.pc) : '0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized + directed bench for inst_fetch_queue against a queue-level
// model; one instance starts at 0, another at all-ones to exercise wrap.
module tb_inst_fetch_queue;
    import inst_fetch_queue_pkg::*;

    logic     clk;
    logic     reset;
    logic     redirect;
    address_t redirect_pc;
    logic     decode_ready;

    logic     en    [2];
    address_t addr  [2];
    inst_t    data  [2];
    logic     valid [2];
    inst_t    inst  [2];
    address_t pc    [2];
    address_t npc   [2];

    int checks = 0;
    int errors = 0;
    bit armed  = 0;

    // Behavioural model: ordered list of pcs that will appear at decode,
    // plus the one fetch whose word is on its way back.
    address_t mq   [2][0:7];
    int       mn   [2];
    address_t mfpc [2];
    bit       minf [2];
    address_t mipc [2];
    bit       post_rst [2];

    function automatic inst_t mem_word(input address_t a);
        return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    function automatic address_t rst_pc(input int k);
        return (k == 0) ? 32'h0 : 32'hFFFF_FFFF;
    endfunction

    inst_fetch_queue #(.QUEUE_DEPTH(2), .RESET_PC(32'h0)) dut0 (
        .clk(clk), .reset(reset),
        .imem_en(en[0]), .imem_addr(addr[0]), .imem_data(data[0]),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .decode_ready(decode_ready),
        .valid(valid[0]), .inst(inst[0]), .pc(pc[0]), .npc(npc[0])
    );

    inst_fetch_queue #(.QUEUE_DEPTH(2), .RESET_PC(32'hFFFF_FFFF)) dut1 (
        .clk(clk), .reset(reset),
        .imem_en(en[1]), .imem_addr(addr[1]), .imem_data(data[1]),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .decode_ready(decode_ready),
        .valid(valid[1]), .inst(inst[1]), .pc(pc[1]), .npc(npc[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: word returns one cycle after the request,
    // garbage otherwise so an unrequested capture is visible.
    always @(posedge clk) data[0] <= en[0] ? mem_word(addr[0]) : $urandom;
    always @(posedge clk) data[1] <= en[1] ? mem_word(addr[1]) : $urandom;

    task automatic chk(input int k, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL dut%0d %s: got %h expected %h", k, name, act, exp);
        end
    endtask

    task automatic step(input logic rdy, input logic rd,
                        input address_t rpc, input logic rs);
        @(negedge clk);
        decode_ready = rdy;
        redirect     = rd;
        redirect_pc  = rpc;
        reset        = rs;
        #1;
        for (int k = 0; k < 2; k++) begin
            bit ev, p, een;
            ev = (mn[k] != 0);
            p  = ev & rdy & ~rd;
            een = !rs && !rd && ((mn[k] + int'(minf[k]) - int'(p)) < 2);
            if (armed) begin
                chk(k, "valid", valid[k], ev);
                if (ev) begin
                    chk(k, "pc", pc[k], mq[k][0]);
                    chk(k, "inst", inst[k], mem_word(mq[k][0]));
                    chk(k, "npc", npc[k], mq[k][0] + 32'd1);
                end
                if (post_rst[k]) begin
                    chk(k, "rst_pc", pc[k], 0);
                    chk(k, "rst_inst", inst[k], 0);
                    chk(k, "rst_npc", npc[k], 0);
                end
                chk(k, "imem_en", en[k], een);
                if (een) chk(k, "imem_addr", addr[k], mfpc[k]);
            end
            if (rs) begin
                mn[k] = 0;
                minf[k] = 0;
                mfpc[k] = rst_pc(k);
            end else if (rd) begin
                mn[k] = 0;
                minf[k] = 0;
                mfpc[k] = rpc;
            end else begin
                if (p) begin
                    for (int i = 0; i < 7; i++) mq[k][i] = mq[k][i+1];
                    mn[k]--;
                end
                if (minf[k]) begin
                    mq[k][mn[k]] = mipc[k];
                    mn[k]++;
                end
                minf[k] = een;
                if (een) begin
                    mipc[k] = mfpc[k];
                    mfpc[k] = mfpc[k] + 32'd1;
                end
            end
            post_rst[k] = rs;
        end
    endtask

    initial begin
        decode_ready = 0;
        redirect     = 0;
        redirect_pc  = '0;
        reset        = 1;
        for (int k = 0; k < 2; k++) begin
            mn[k] = 0; minf[k] = 0; mfpc[k] = rst_pc(k);
            mipc[k] = '0; post_rst[k] = 0;
        end

        step(0, 0, 0, 1);
        armed = 1;
        step(0, 0, 0, 1);

        // Streaming from reset
        step(1, 0, 0, 0);
        chk(0, "c0_en", en[0], 1);
        chk(0, "c0_addr", addr[0], 32'h0);
        chk(1, "c0_addr", addr[1], 32'hFFFF_FFFF);
        chk(0, "c0_valid", valid[0], 0);
        step(1, 0, 0, 0);
        chk(0, "c1_addr", addr[0], 32'h1);
        step(1, 0, 0, 0);
        chk(0, "c2_pc", pc[0], 32'h0);
        chk(0, "c2_npc", npc[0], 32'h1);
        chk(1, "c2_pc", pc[1], 32'hFFFF_FFFF);
        chk(1, "c2_npc", npc[1], 32'h0);
        step(1, 0, 0, 0);
        chk(0, "c3_pc", pc[0], 32'h1);
        chk(1, "c3_pc", pc[1], 32'h0);
        repeat (4) step(1, 0, 0, 0);

        // Stall
        repeat (6) step(0, 0, 0, 0);
        chk(0, "stall_en", en[0], 0);
        chk(0, "stall_valid", valid[0], 1);
        repeat (4) step(1, 0, 0, 0);

        // Redirect with valid head, ready high and a fetch in flight
        step(1, 1, 32'h40, 0);
        step(1, 0, 0, 0);
        chk(0, "rd1_valid", valid[0], 0);
        chk(0, "rd1_en", en[0], 1);
        chk(0, "rd1_addr", addr[0], 32'h40);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk(0, "rd3_pc", pc[0], 32'h40);
        step(1, 0, 0, 0);
        chk(0, "rd4_pc", pc[0], 32'h41);

        // One-cycle reset pulse mid-stream
        repeat (3) step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        step(1, 0, 0, 0);
        chk(0, "rp_valid", valid[0], 0);
        chk(0, "rp_pc", pc[0], 0);
        chk(0, "rp_addr", addr[0], 32'h0);
        chk(1, "rp_addr", addr[1], 32'hFFFF_FFFF);

        // Random traffic
        repeat (600) begin
            logic     r_rdy, r_rd, r_rs;
            address_t r_pc;
            r_rdy = ($urandom % 10) < 7;
            r_rd  = ($urandom % 20) == 0;
            r_rs  = ($urandom % 60) == 0;
            r_pc  = ($urandom % 4 == 0) ? (32'hFFFF_FFFF - ($urandom % 3))
                                        : address_t'($urandom);
            step(r_rdy, r_rd, r_pc, r_rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction fetch front end that owns the program counter and fetches from the word-addressed instruction memory. It buffers responses in a small prefetch queue and drives the inst/pc/npc fields that the decode stage consumes, with a valid/ready pair added so decode can stall. It sits between instruction memory and decode, and takes branch redirects from the branch/writeback logic.

## Interface
Parameters:
- QUEUE_DEPTH, 2: prefetch queue entries; power of two, ≥2.
- RESET_PC, 0: first fetch address after reset.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- imem_en  out  1  fetch request this cycle.
- imem_addr  out  Address  word address of the request.
- imem_data  in  Inst  instruction; valid exactly 1 cycle after imem_en.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  Address  new fetch address, sampled when redirect=1.
- decode_ready  in  1  decode accepts the head entry this cycle.
- valid  out  1  inst/pc/npc hold a valid instruction.
- inst  out  Inst  head instruction.
- pc  out  Address  address of inst.
- npc  out  Address  pc+1, modulo 2^width(Address).

## Operation
- State:
  - fetch_pc register.
  - Queue of {inst, pc} entries, with occupancy count 0..QUEUE_DEPTH.
  - Inflight flag, plus a kill flag for the response arriving next cycle.
- pop = valid & decode_ready & ~redirect.
- Issue rule: imem_en = ~reset & ~redirect & (occupancy + inflight − pop < QUEUE_DEPTH).
  - On issue, imem_addr = fetch_pc and fetch_pc ← fetch_pc+1, wrapping at the Address maximum.
- Response: when inflight & ~kill, push {imem_data, issued pc} into the queue. The queue never overflows, by the issue rule.
- Outputs come from the queue head registers. valid = (occupancy ≠ 0). npc is computed from the head pc.
- Redirect (priority over everything):
  - Occupancy ← 0.
  - kill ← inflight, so the response returning next cycle is discarded.
  - fetch_pc ← redirect_pc.
  - No issue and no pop in the redirect cycle.
  - The first new fetch of redirect_pc is issued the following cycle.
- Simultaneous push and pop: occupancy unchanged. A push into an empty queue is visible at the outputs next cycle; there is no bypass.
- Stall: with decode_ready=0, the outputs hold stable and fetch stops once occupancy+inflight = QUEUE_DEPTH. No entry is lost or duplicated.
- Reset (also mid-operation):
  - fetch_pc ← RESET_PC; occupancy 0; inflight 0; kill 0.
  - valid=0, inst=0, pc=0, npc=0, imem_en=0.
  - An in-flight response returning during or after reset is ignored.

## Timing
- Cycle 0 (first after reset deasserted): imem_en=1, imem_addr=RESET_PC.
- Cycle 1: response is pushed. Cycle 2: valid=1, pc=RESET_PC, npc=RESET_PC+1.
- Latency from fetch issue to valid: 2 cycles.
- Throughput: 1 instruction/cycle sustained with decode_ready=1 and QUEUE_DEPTH≥2.
- Redirect asserted in cycle t:
  - valid=0 in t+1.
  - imem_en for redirect_pc in t+1.
  - valid with pc=redirect_pc in t+3.
- Combinational path from decode_ready to imem_en is permitted. No path from imem_data to outputs.

## Structure
- Inst and Address come from Pu_types.
- Add Fetch_entry struct {Inst inst; Address pc;} to Pu_types, shared with decode-side tracing.
- Sub-module fetch_fifo: parameterised synchronous FIFO of Fetch_entry with push, pop, flush, count, and head output.
- The top level holds fetch_pc, inflight/kill, and the issue rule.

## Test plan
- Reset, then decode_ready=1 held: imem_addr 0,1,2,… every cycle from cycle 0; valid from cycle 2 with pc 0,1,2,…; npc=pc+1; no gaps.
- decode_ready=0 for 6 cycles mid-stream: outputs frozen; imem_en drops after 2 outstanding (depth 2); after release, the pc sequence continues with no loss or duplicate.
- redirect=1, redirect_pc=0x40 while a fetch is in flight: the in-flight word is discarded; valid=0 next cycle; pc=0x40 appears 3 cycles after redirect, then 0x41.
- redirect and decode_ready both 1 with valid=1: the head is not counted as consumed, the queue flushes, and the stream restarts at redirect_pc.
- RESET_PC = all-ones: first pc=all-ones with npc=0, next pc=0 (wrap).
- reset pulsed for 1 cycle mid-stream with a response in flight: valid=0 and outputs zero the next cycle; the stale response is not pushed; fetch restarts at RESET_PC.
